rs_multi_cdb: RTL and testbench

- Parametrised successor of the ALU reservation station in the out-of-order RISC-V core.
- Sits between the issue stage and the ALU.
- Holds issued ALU ops and snoops CDB_N result buses for pending operands.
- Dispatches the oldest ready entry to the ALU under an alu_ready back-pressure handshake.

---
 rtl/rs_pkg.sv | 30 +++
 rtl/rs_age_picker.sv | 18 +
 rtl/rs_multi_cdb.sv | 177 +++++++++++++++++
 tb/tb_rs_multi_cdb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and constants for the ALU reservation station.
package rs_pkg;

  localparam int RS_ROB_W = 4;
  localparam int RS_XLEN  = 32;
  // Bit position of the "operand pending" flag inside an operand tag.
  localparam int TAG_PEND = RS_ROB_W;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                funct7;
    logic [RS_XLEN-1:0]  imm;
    logic [RS_XLEN-1:0]  pc;
    logic [RS_ROB_W-1:0] rob_pos;
    logic [RS_XLEN-1:0]  val1;
    logic [RS_XLEN-1:0]  val2;
    logic [RS_ROB_W:0]   tag1;
    logic [RS_ROB_W:0]   tag2;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_picker.sv
// Oldest-ready selector: grants the ready entry that has no older ready entry.
module rs_age_picker #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]             ready,
  input  logic [DEPTH-1:0][DEPTH-1:0]  older,
  output logic [DEPTH-1:0]             grant,
  output logic                         valid
);

  // older[i][j] = 1 means entry j was issued before entry i.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      grant[i] = ready[i] && ((older[i] & ready) == '0);
    valid = |ready;
  end

endmodule

// File: rtl/rs_multi_cdb.sv
// ALU reservation station with multi-channel CDB snooping and age-ordered dispatch.
module rs_multi_cdb
  import rs_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ROB_W = RS_ROB_W,
  parameter int CDB_N = 2,
  parameter int XLEN  = RS_XLEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        rollback,
  output logic                        rs_nxt_full,
  output logic [$clog2(DEPTH):0]      occupancy,
  input  logic                        issue,
  input  logic [ROB_W-1:0]            issue_rob_pos,
  input  logic [6:0]                  issue_opcode,
  input  logic [2:0]                  issue_funct3,
  input  logic                        issue_funct7,
  input  logic [XLEN-1:0]             issue_imm,
  input  logic [XLEN-1:0]             issue_pc,
  input  logic [XLEN-1:0]             issue_rs1_val,
  input  logic [XLEN-1:0]             issue_rs2_val,
  input  logic [ROB_W:0]              issue_rs1_rob_id,
  input  logic [ROB_W:0]              issue_rs2_rob_id,
  input  logic                        alu_ready,
  output logic                        alu_en,
  output logic [6:0]                  alu_opcode,
  output logic [2:0]                  alu_funct3,
  output logic                        alu_funct7,
  output logic [XLEN-1:0]             alu_imm,
  output logic [XLEN-1:0]             alu_pc,
  output logic [ROB_W-1:0]            alu_rob_pos,
  output logic [XLEN-1:0]             alu_val1,
  output logic [XLEN-1:0]             alu_val2,
  input  logic [CDB_N-1:0]            cdb_valid,
  input  logic [CDB_N*ROB_W-1:0]      cdb_rob_pos,
  input  logic [CDB_N*XLEN-1:0]       cdb_val
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rs_entry_t                   ent  [DEPTH];
  rs_entry_t                   woke [DEPTH];
  rs_entry_t                   new_ent;
  rs_entry_t                   sel_ent;
  logic [DEPTH-1:0]            busy, ready, grant, disp_vec;
  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic                        any_ready, dispatch, issue_acc;
  logic [IDX_W-1:0]            free_idx;

  // Returns {tag, val} after snooping the CDB; lowest matching channel wins.
  function automatic logic [ROB_W+XLEN:0] snoop(
    input logic [ROB_W:0]         tag,
    input logic [XLEN-1:0]        val,
    input logic [CDB_N-1:0]       cv,
    input logic [CDB_N*ROB_W-1:0] cp,
    input logic [CDB_N*XLEN-1:0]  cd
  );
    logic [ROB_W+XLEN:0] r;
    r = {tag, val};
    for (int k = CDB_N - 1; k >= 0; k--)
      if (tag[TAG_PEND] && cv[k] && cp[k*ROB_W +: ROB_W] == tag[ROB_W-1:0])
        r = {{(ROB_W + 1){1'b0}}, cd[k*XLEN +: XLEN]};
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      ready[i] = busy[i] && !ent[i].tag1[TAG_PEND] && !ent[i].tag2[TAG_PEND];
  end

  rs_age_picker #(.DEPTH(DEPTH)) u_pick (
    .ready (ready),
    .older (older),
    .grant (grant),
    .valid (any_ready)
  );

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) free_idx = IDX_W'(i);
  end

  // A slot freed by this cycle's dispatch is not visible to issue until next cycle.
  assign issue_acc   = issue && !(&busy);
  assign dispatch    = rdy && alu_ready && any_ready;
  assign disp_vec    = dispatch ? grant : '0;
  assign rs_nxt_full = (occupancy == CNT_W'(DEPTH)) ||
                       ((occupancy == CNT_W'(DEPTH - 1)) && issue);

  always_comb begin
    sel_ent = '0;
    for (int i = 0; i < DEPTH; i++)
      if (grant[i]) sel_ent = ent[i];
  end

  always_comb begin
    new_ent         = '0;
    new_ent.opcode  = issue_opcode;
    new_ent.funct3  = issue_funct3;
    new_ent.funct7  = issue_funct7;
    new_ent.imm     = issue_imm;
    new_ent.pc      = issue_pc;
    new_ent.rob_pos = issue_rob_pos;
    {new_ent.tag1, new_ent.val1} =
      snoop(issue_rs1_rob_id, issue_rs1_val, cdb_valid, cdb_rob_pos, cdb_val);
    {new_ent.tag2, new_ent.val2} =
      snoop(issue_rs2_rob_id, issue_rs2_val, cdb_valid, cdb_rob_pos, cdb_val);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent[i];
      if (busy[i]) begin
        {woke[i].tag1, woke[i].val1} =
          snoop(ent[i].tag1, ent[i].val1, cdb_valid, cdb_rob_pos, cdb_val);
        {woke[i].tag2, woke[i].val2} =
          snoop(ent[i].tag2, ent[i].val2, cdb_valid, cdb_rob_pos, cdb_val);
      end
    end
  end

  // Payload needs no reset: busy gates every use of it.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= woke[i];
      if (issue_acc) ent[free_idx] <= new_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      busy      <= '0;
      older     <= '0;
      occupancy <= '0;
      alu_en    <= 1'b0;
    end else if (rdy) begin
      alu_en    <= dispatch;
      occupancy <= occupancy + CNT_W'(issue_acc) - CNT_W'(dispatch);
      busy      <= busy & ~disp_vec;
      for (int i = 0; i < DEPTH; i++)
        for (int j = 0; j < DEPTH; j++)
          older[i][j] <= older[i][j] && !disp_vec[i] && !disp_vec[j];
      if (issue_acc) begin
        busy[free_idx]  <= 1'b1;
        older[free_idx] <= busy & ~disp_vec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
      alu_val1    <= '0;
      alu_val2    <= '0;
    end else if (!rollback && dispatch) begin
      alu_opcode  <= sel_ent.opcode;
      alu_funct3  <= sel_ent.funct3;
      alu_funct7  <= sel_ent.funct7;
      alu_imm     <= sel_ent.imm;
      alu_pc      <= sel_ent.pc;
      alu_rob_pos <= sel_ent.rob_pos;
      alu_val1    <= sel_ent.val1;
      alu_val2    <= sel_ent.val2;
    end
  end

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed self-checking bench for rs_multi_cdb: vector table plus hand sequences.
module tb_rs_multi_cdb;

  localparam int DEPTH = 16;
  localparam int ROB_W = 4;
  localparam int CDB_N = 2;
  localparam int XLEN  = 32;

  logic                   clk = 1'b0;
  logic                   rst, rdy, rollback, issue, alu_ready;
  logic                   rs_nxt_full;
  logic [4:0]             occupancy;
  logic [ROB_W-1:0]       issue_rob_pos;
  logic [6:0]             issue_opcode;
  logic [2:0]             issue_funct3;
  logic                   issue_funct7;
  logic [XLEN-1:0]        issue_imm, issue_pc, issue_rs1_val, issue_rs2_val;
  logic [ROB_W:0]         issue_rs1_rob_id, issue_rs2_rob_id;
  logic                   alu_en;
  logic [6:0]             alu_opcode;
  logic [2:0]             alu_funct3;
  logic                   alu_funct7;
  logic [XLEN-1:0]        alu_imm, alu_pc, alu_val1, alu_val2;
  logic [ROB_W-1:0]       alu_rob_pos;
  logic [CDB_N-1:0]       cdb_valid;
  logic [CDB_N*ROB_W-1:0] cdb_rob_pos;
  logic [CDB_N*XLEN-1:0]  cdb_val;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rs_multi_cdb #(.DEPTH(DEPTH), .ROB_W(ROB_W), .CDB_N(CDB_N), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .rs_nxt_full(rs_nxt_full), .occupancy(occupancy),
    .issue(issue), .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode),
    .issue_funct3(issue_funct3), .issue_funct7(issue_funct7), .issue_imm(issue_imm),
    .issue_pc(issue_pc), .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .issue_rs1_rob_id(issue_rs1_rob_id), .issue_rs2_rob_id(issue_rs2_rob_id),
    .alu_ready(alu_ready), .alu_en(alu_en), .alu_opcode(alu_opcode),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val)
  );

  typedef struct {
    logic        iss;
    logic [3:0]  rob;
    logic [4:0]  t1;
    logic [31:0] v1;
    logic [4:0]  t2;
    logic [31:0] v2;
    logic [1:0]  cv;
    logic [3:0]  p0;
    logic [31:0] d0;
    logic [3:0]  p1;
    logic [31:0] d1;
    logic        en;
    logic [3:0]  erob;
    logic [31:0] ev1;
    logic [31:0] ev2;
    logic [4:0]  eocc;
  } vec_t;

  vec_t tv [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [3:0] rob, input logic [4:0] t1, input logic [31:0] v1,
                           input logic [4:0] t2, input logic [31:0] v2);
    issue            = 1'b1;
    issue_rob_pos    = rob;
    issue_opcode     = 7'b0110011;
    issue_funct3     = rob[2:0];
    issue_funct7     = rob[3];
    issue_imm        = {28'd0, rob};
    issue_pc         = 32'h1000 + {28'd0, rob};
    issue_rs1_rob_id = t1;
    issue_rs1_val    = v1;
    issue_rs2_rob_id = t2;
    issue_rs2_val    = v2;
  endtask

  task automatic clear_in();
    issue     = 1'b0;
    cdb_valid = '0;
    cdb_rob_pos = '0;
    cdb_val   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; alu_ready = 1'b1;
    set_issue(4'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    clear_in();

    // age order, pending on rob 9
    tv[0]  = '{1, 4'd3, 5'h19, 0, 0, 0,      0, 0, 0, 0, 0,          0, 0, 0, 0, 1};
    tv[1]  = '{1, 4'd7, 5'h19, 0, 0, 0,      0, 0, 0, 0, 0,          0, 0, 0, 0, 2};
    tv[2]  = '{1, 4'd1, 5'h19, 0, 0, 0,      0, 0, 0, 0, 0,          0, 0, 0, 0, 3};
    tv[3]  = '{0, 0, 0, 0, 0, 0,             2'b01, 9, 32'hAB, 0, 0, 0, 0, 0, 0, 3};
    tv[4]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0,          1, 3, 32'hAB, 0, 2};
    tv[5]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0,          1, 7, 32'hAB, 0, 1};
    tv[6]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0,          1, 1, 32'hAB, 0, 0};
    tv[7]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0,          0, 0, 0, 0, 0};
    // dual CDB
    tv[8]  = '{1, 4'd5, 5'h12, 0, 5'h15, 0,  0, 0, 0, 0, 0,          0, 0, 0, 0, 1};
    tv[9]  = '{0, 0, 0, 0, 0, 0,             2'b11, 2, 32'h11, 5, 32'h22, 0, 0, 0, 0, 1};
    tv[10] = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0,          1, 5, 32'h11, 32'h22, 0};
    // issue bypass on channel 1
    tv[11] = '{1, 4'd6, 5'h14, 0, 0, 32'h77, 2'b10, 0, 0, 4, 32'h55, 0, 0, 0, 0, 1};
    tv[12] = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0,          1, 6, 32'h55, 32'h77, 0};
    // both channels match: channel 0 wins
    tv[13] = '{1, 4'd2, 5'h18, 0, 0, 32'h1,  0, 0, 0, 0, 0,          0, 0, 0, 0, 1};
    tv[14] = '{0, 0, 0, 0, 0, 0,             2'b11, 8, 32'hC0, 8, 32'hC1, 0, 0, 0, 0, 1};
    tv[15] = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0,          1, 2, 32'hC0, 32'h1, 0};
    // same-cycle issue and dispatch
    tv[16] = '{1, 4'd4, 0, 32'h44, 0, 32'h45, 0, 0, 0, 0, 0,         0, 0, 0, 0, 1};
    tv[17] = '{1, 4'd8, 0, 32'h88, 0, 32'h89, 0, 0, 0, 0, 0,         1, 4, 32'h44, 32'h45, 1};
    tv[18] = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0,          1, 8, 32'h88, 32'h89, 0};

    tick(); tick();
    chk("reset occupancy", 32'(occupancy), 0);
    chk("reset alu_en", 32'(alu_en), 0);
    chk("reset rs_nxt_full", 32'(rs_nxt_full), 0);
    chk("reset alu_val1", alu_val1, 0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      clear_in();
      if (tv[i].iss) set_issue(tv[i].rob, tv[i].t1, tv[i].v1, tv[i].t2, tv[i].v2);
      cdb_valid   = tv[i].cv;
      cdb_rob_pos = {tv[i].p1, tv[i].p0};
      cdb_val     = {tv[i].d1, tv[i].d0};
      tick();
      chk($sformatf("vec%0d alu_en", i), 32'(alu_en), 32'(tv[i].en));
      chk($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(tv[i].eocc));
      if (tv[i].en) begin
        chk($sformatf("vec%0d alu_rob_pos", i), 32'(alu_rob_pos), 32'(tv[i].erob));
        chk($sformatf("vec%0d alu_val1", i), alu_val1, tv[i].ev1);
        chk($sformatf("vec%0d alu_val2", i), alu_val2, tv[i].ev2);
        chk($sformatf("vec%0d alu_pc", i), alu_pc, 32'h1000 + 32'(tv[i].erob));
      end
    end
    clear_in();

    // rdy=0 freezes everything, including alu_en
    alu_ready = 1'b0;
    set_issue(4'd9, 5'd0, 32'h99, 5'd0, 32'd0);
    tick();
    clear_in();
    chk("rdy occupancy after issue", 32'(occupancy), 1);
    rdy = 1'b0; alu_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy0 alu_en held low", 32'(alu_en), 0);
      chk("rdy0 occupancy held", 32'(occupancy), 1);
    end
    rdy = 1'b1;
    tick();
    chk("rdy1 dispatch alu_en", 32'(alu_en), 1);
    chk("rdy1 dispatch rob", 32'(alu_rob_pos), 9);
    rdy = 1'b0;
    tick();
    chk("rdy0 alu_en held high", 32'(alu_en), 1);
    rdy = 1'b1;
    tick();
    chk("rdy1 alu_en drops", 32'(alu_en), 0);

    // back-pressure
    alu_ready = 1'b0;
    set_issue(4'd10, 5'd0, 32'hA0, 5'd0, 32'd0);
    tick();
    set_issue(4'd11, 5'd0, 32'hB0, 5'd0, 32'd0);
    tick();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp alu_en low", 32'(alu_en), 0);
      chk("bp occupancy", 32'(occupancy), 2);
    end
    alu_ready = 1'b1;
    tick();
    chk("bp first alu_en", 32'(alu_en), 1);
    chk("bp first rob", 32'(alu_rob_pos), 10);
    tick();
    chk("bp second alu_en", 32'(alu_en), 1);
    chk("bp second rob", 32'(alu_rob_pos), 11);
    chk("bp second val1", alu_val1, 32'hB0);
    tick();
    chk("bp drained alu_en", 32'(alu_en), 0);
    chk("bp drained occupancy", 32'(occupancy), 0);

    // full boundary
    alu_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      set_issue(4'(i), 5'd0, 32'h100 + 32'(i), 5'd0, 32'd0);
      #1;
      if (i == 14) chk("full nxt_full at occ14+issue", 32'(rs_nxt_full), 0);
      tick();
    end
    chk("full occupancy 15", 32'(occupancy), 15);
    set_issue(4'd15, 5'd0, 32'h10F, 5'd0, 32'd0);
    #1;
    chk("full nxt_full at occ15+issue", 32'(rs_nxt_full), 1);
    tick();
    chk("full occupancy 16", 32'(occupancy), 16);
    clear_in();
    #1;
    chk("full nxt_full at occ16", 32'(rs_nxt_full), 1);
    set_issue(4'd5, 5'd0, 32'hDEAD, 5'd0, 32'd0);
    tick();
    clear_in();
    chk("full dropped issue occupancy", 32'(occupancy), 16);
    alu_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("drain%0d alu_en", k), 32'(alu_en), 1);
      chk($sformatf("drain%0d rob", k), 32'(alu_rob_pos), 32'(k));
      chk($sformatf("drain%0d val1", k), alu_val1, 32'h100 + 32'(k));
    end
    tick();
    chk("drain done alu_en", 32'(alu_en), 0);
    chk("drain done occupancy", 32'(occupancy), 0);

    // rollback flush with ready entries waiting
    alu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_issue(4'(i), 5'd0, 32'h200 + 32'(i), 5'd0, 32'd0);
      tick();
    end
    clear_in();
    chk("rb occupancy before", 32'(occupancy), 5);
    rollback = 1'b1; alu_ready = 1'b1;
    tick();
    rollback = 1'b0;
    chk("rb occupancy", 32'(occupancy), 0);
    chk("rb alu_en", 32'(alu_en), 0);
    chk("rb rs_nxt_full", 32'(rs_nxt_full), 0);
    chk("rb alu_val1 held", alu_val1, 32'h10F);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rb no dispatch after", 32'(alu_en), 0);
      chk("rb occupancy stays 0", 32'(occupancy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
